fifo_wr_adapter: RTL and testbench
==================================

FIFO_WR_ADAPTER -- requirements
Module: fifo_wr_adapter

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of the stream and FIFO write data.
REQ-002 Parameter BURST_LEN, default 8, legal range >=1: maximum number of FIFO writes per burst.
REQ-003 Parameter CNT_WIDTH, default 32: width of the statistics counters.
REQ-004 wr_clk  input  1  write-domain clock; all state is clocked on its rising edge.
REQ-005 wr_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 s_valid  input  1  upstream word valid.
REQ-007 s_data  input  DATA_WIDTH  upstream word.
REQ-008 s_ready  output  1  adapter can accept a word; registered.
REQ-009 fifo_full  input  1  full flag from the async FIFO write port.
REQ-010 fifo_almost_full  input  1  almost-full flag from the async FIFO write port.
REQ-011 wr_en  output  1  FIFO write strobe.
REQ-012 wr_data  output  DATA_WIDTH  FIFO write data.
REQ-013 word_cnt  output  CNT_WIDTH  total words written to the FIFO; wraps.
REQ-014 stall_cnt  output  CNT_WIDTH  cycles spent in HOLD; wraps.

Function
REQ-015 Handshake: a word transfers on a rising edge where s_valid=1 and s_ready=1; s_data is ignored otherwise.
REQ-016 Input stage: 2-entry in-order buffer; next s_ready = (next occupancy <= 1), counting the push and pop of the current cycle.
REQ-017 FSM states: IDLE, BURST, HOLD; reset state IDLE.
REQ-018 IDLE -> BURST when occupancy >= 1 and fifo_almost_full=0; this transition loads burst_rem with BURST_LEN.
REQ-019 wr_en = (state==BURST) && occupancy>=1 && !fifo_full; it is combinational from registers and fifo_full only, with no path from s_valid or s_data.
REQ-020 wr_data = buffer head; a wr_en cycle pops the head and decrements burst_rem.
REQ-021 BURST -> IDLE on a write with burst_rem==1, or on any cycle with occupancy==0.
REQ-022 BURST -> HOLD on a cycle with fifo_full=1 and occupancy>=1; HOLD -> BURST when fifo_full=0; burst_rem is preserved across HOLD.
REQ-023 wr_en SHALL never be 1 while fifo_full=1.
REQ-024 fifo_almost_full is checked only at burst start; a burst already in progress continues until fifo_full.
REQ-025 Latency: for a word accepted in IDLE with an empty buffer, wr_en rises 2 cycles after the handshake edge; within a burst, 1 word is written per cycle.
REQ-026 Words SHALL exit in acceptance order with no loss or duplication.
REQ-027 Counters: word_cnt increments on each wr_en; stall_cnt increments each cycle in HOLD; both wrap modulo 2^CNT_WIDTH.
REQ-028 Push into a buffer that becomes empty in the same cycle: the word is retained, and the FSM follows REQ-021 and re-enters BURST via IDLE.

Reset
REQ-029 wr_rst_n low SHALL immediately force: state IDLE, buffer empty, burst_rem 0, s_ready 0, wr_en 0, wr_data 0, word_cnt 0, stall_cnt 0.
REQ-030 Reset mid-burst SHALL discard buffered words; s_ready rises on the first wr_clk edge after release.

Structure
REQ-031 Package fifo_wr_pkg SHALL hold the FSM state enum and the default DATA_WIDTH, BURST_LEN and CNT_WIDTH constants.
REQ-032 Sub-module wr_skid_buf SHALL implement the 2-entry buffer and registered s_ready; the FSM and counters reside in fifo_wr_adapter.

Verification
REQ-033 Reset: hold wr_rst_n low for 10 cycles with s_valid=1 -> s_ready=0, wr_en=0, counters 0; after release, s_ready=1 after the first edge.
REQ-034 Stream 0x0000..0x0013 back-to-back with both flags low -> wr_data is 0x0000..0x0013 in order, in bursts of 8, 8, 4 with one idle cycle between bursts; first wr_en is 2 cycles after the first handshake; word_cnt=20.
REQ-035 fifo_almost_full=1 from the start while sending 3 words -> no wr_en and s_ready=0 after 2 words buffered; deassert the flag -> 0,1,2 written in order, word_cnt=3.
REQ-036 fifo_full=1 for 5 cycles after the 3rd write of a burst -> wr_en=0 throughout, stall_cnt=5, then the remaining 5 burst words are written with no gap or duplicate.
REQ-037 Assert wr_rst_n mid-burst with 2 words buffered -> wr_en drops without waiting for a clock and counters clear; a post-reset stream starting at 0x0100 produces 0x0100 as its first wr_data.
REQ-038 BURST_LEN=1, 4-word stream -> each write is followed by one IDLE cycle, and fifo_almost_full is rechecked before each write.

Source files
------------

// File: rtl/fifo_wr_pkg.sv
// Shared types and default sizing for the FIFO write-side adapter.
package fifo_wr_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_BURST_LEN  = 8;
  localparam int DEF_CNT_WIDTH  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_HOLD  = 2'd2
  } wr_state_t;

  // Bits needed to hold a remaining-burst count in 0..len.
  function automatic int rem_width(input int len);
    return (len < 1) ? 1 : $clog2(len + 1);
  endfunction

endpackage

// File: rtl/wr_skid_buf.sv
// Two-entry in-order input buffer with a registered ready; the consumer pops the head.
module wr_skid_buf
  import fifo_wr_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] mem_reg [2];
  logic                  rd_ptr_reg;
  logic                  wr_ptr_reg;
  logic [1:0]            occ_reg;
  logic                  ready_reg;

  logic                  push;
  logic                  pop_ok;
  logic [1:0]            occ_next;
  logic                  ready_next;

  always_comb begin
    push       = s_valid && ready_reg;
    pop_ok     = pop && (occ_reg != 2'd0);
    occ_next   = occ_reg + {1'b0, push} - {1'b0, pop_ok};
    // Ready looks ahead at this cycle's push and pop so a steady stream never bubbles.
    ready_next = (occ_next <= 2'd1);
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_reg[i] <= '0;
      end
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      occ_reg    <= 2'd0;
      ready_reg  <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push && (wr_ptr_reg == 1'(i))) begin
          mem_reg[i] <= s_data;
        end
      end
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop_ok) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      occ_reg   <= occ_next;
      ready_reg <= ready_next;
    end
  end

  assign s_ready   = ready_reg;
  assign head      = mem_reg[rd_ptr_reg];
  assign occupancy = occ_reg;

endmodule

// File: rtl/fifo_wr_adapter.sv
// Stream-to-FIFO write adapter: buffers upstream words and writes them in bounded
// bursts, pausing on full and only starting a burst when the FIFO is not almost full.
module fifo_wr_adapter
  import fifo_wr_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  fifo_full,
  input  logic                  fifo_almost_full,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  localparam int REM_W = rem_width(BURST_LEN);

  wr_state_t             state_reg;
  logic [REM_W-1:0]      burst_rem_reg;
  logic [CNT_WIDTH-1:0]  word_cnt_reg;
  logic [CNT_WIDTH-1:0]  stall_cnt_reg;

  logic [1:0]            occupancy;
  logic [DATA_WIDTH-1:0] head;
  logic                  has_data;

  wr_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .wr_clk   (wr_clk),
    .wr_rst_n (wr_rst_n),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .pop      (wr_en),
    .head     (head),
    .occupancy(occupancy)
  );

  // The write strobe depends only on registered state and fifo_full, never on the upstream side.
  assign has_data = (occupancy != 2'd0);
  assign wr_en    = (state_reg == ST_BURST) && has_data && !fifo_full;
  assign wr_data  = head;

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_reg     <= ST_IDLE;
      burst_rem_reg <= '0;
      word_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (wr_en) begin
        word_cnt_reg <= word_cnt_reg + CNT_WIDTH'(1);
      end
      case (state_reg)
        ST_IDLE: begin
          if (has_data && !fifo_almost_full) begin
            state_reg     <= ST_BURST;
            burst_rem_reg <= REM_W'(BURST_LEN);
          end
        end
        ST_BURST: begin
          if (!has_data) begin
            state_reg <= ST_IDLE;
          end else if (fifo_full) begin
            state_reg <= ST_HOLD;
          end else begin
            burst_rem_reg <= burst_rem_reg - REM_W'(1);
            if (burst_rem_reg == REM_W'(1)) begin
              state_reg <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          // Remaining burst budget is kept untouched while stalled.
          stall_cnt_reg <= stall_cnt_reg + CNT_WIDTH'(1);
          if (!fifo_full) begin
            state_reg <= ST_BURST;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign word_cnt  = word_cnt_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_fifo_wr_adapter.sv
// Directed and randomized checks of fifo_wr_adapter against a queue-based model of accepted words.
module tb_fifo_wr_adapter;

  logic        wr_clk = 1'b0;
  logic        wr_rst_n = 1'b1;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        fifo_full = 1'b0;
  logic        fifo_almost_full = 1'b0;

  logic        ready_a, wr_en_a, ready_b, wr_en_b;
  logic [15:0] wr_data_a, wr_data_b;
  logic [31:0] word_cnt_a, stall_cnt_a, word_cnt_b, stall_cnt_b;

  logic        o_ready, o_wr_en;
  logic [15:0] o_wr_data;
  logic [31:0] o_word_cnt, o_stall_cnt;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [15:0] q[$];
  int          writes = 0;
  bit          use_b = 1'b0;
  bit          fresh = 1'b0;
  bit          in_rst = 1'b0;
  int          src_base = 0, src_n = 0, src_idx = 0, valid_pct = 100;
  bit          wr_trace[$];
  int          runs[$], gaps[$];
  int          tick_no = 0, hs_first = -1, wr_first = -1;
  logic [15:0] first_data = '0;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_adapter #(.DATA_WIDTH(16), .BURST_LEN(8), .CNT_WIDTH(32)) dut_a (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .s_valid(s_valid), .s_data(s_data),
    .s_ready(ready_a), .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full),
    .wr_en(wr_en_a), .wr_data(wr_data_a), .word_cnt(word_cnt_a), .stall_cnt(stall_cnt_a)
  );

  fifo_wr_adapter #(.DATA_WIDTH(16), .BURST_LEN(1), .CNT_WIDTH(32)) dut_b (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .s_valid(s_valid), .s_data(s_data),
    .s_ready(ready_b), .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full),
    .wr_en(wr_en_b), .wr_data(wr_data_b), .word_cnt(word_cnt_b), .stall_cnt(stall_cnt_b)
  );

  always_comb begin
    o_ready     = use_b ? ready_b     : ready_a;
    o_wr_en     = use_b ? wr_en_b     : wr_en_a;
    o_wr_data   = use_b ? wr_data_b   : wr_data_a;
    o_word_cnt  = use_b ? word_cnt_b  : word_cnt_a;
    o_stall_cnt = use_b ? stall_cnt_b : stall_cnt_a;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qget(input int qq[$], input int i);
    return (i < qq.size()) ? qq[i] : -1;
  endfunction

  task automatic drive_src();
    if (src_idx < src_n && $urandom_range(99) < valid_pct) begin
      s_valid = 1'b1;
      s_data  = 16'(src_base + src_idx);
    end else begin
      s_valid = 1'b0;
      s_data  = 16'($urandom);
    end
  endtask

  // One clock: called at a falling edge with inputs set; checks, updates the model, steps.
  task automatic cycle();
    bit hs;
    #1;
    check("s_ready", {31'd0, o_ready}, (in_rst || fresh) ? 32'd0 : {31'd0, q.size() <= 1});
    check("word_cnt", o_word_cnt, 32'(writes));
    check("wr_en_empty", {31'd0, o_wr_en && (q.size() == 0)}, 32'd0);
    check("wr_en_full", {31'd0, o_wr_en && fifo_full}, 32'd0);
    if (o_wr_en && q.size() > 0) begin
      check("wr_data", {16'd0, o_wr_data}, {16'd0, q[0]});
      void'(q.pop_front());
      writes++;
    end
    hs = s_valid && o_ready && !in_rst;
    if (hs) begin
      q.push_back(s_data);
      src_idx++;
      if (hs_first < 0) hs_first = tick_no;
    end
    if (!in_rst) begin
      wr_trace.push_back(o_wr_en);
      if (o_wr_en && wr_first < 0) begin
        wr_first   = tick_no;
        first_data = o_wr_data;
      end
    end
    tick_no++;
    @(negedge wr_clk);
    fresh = 1'b0;
  endtask

  task automatic step();
    drive_src();
    cycle();
  endtask

  task automatic do_reset(input int n);
    wr_rst_n = 1'b0;
    in_rst   = 1'b1;
    q.delete();
    writes  = 0;
    s_valid = 1'b1;
    s_data  = 16'hdead;
    repeat (n) begin
      cycle();
      check("rst_stall_cnt", o_stall_cnt, 32'd0);
      check("rst_wr_data", {16'd0, o_wr_data}, 32'd0);
    end
    wr_rst_n = 1'b1;
    in_rst   = 1'b0;
    fresh    = 1'b1;
    s_valid  = 1'b0;
    fifo_full = 1'b0;
    fifo_almost_full = 1'b0;
    wr_trace.delete();
    tick_no = 0; hs_first = -1; wr_first = -1;
    src_idx = 0; valid_pct = 100;
  endtask

  task automatic analyze();
    int run = 0, gap = 0;
    bit started = 1'b0;
    runs.delete();
    gaps.delete();
    foreach (wr_trace[i]) begin
      if (wr_trace[i]) begin
        if (started && run == 0) gaps.push_back(gap);
        run++; started = 1'b1; gap = 0;
      end else begin
        if (run > 0) begin runs.push_back(run); run = 0; end
        gap++;
      end
    end
    if (run > 0) runs.push_back(run);
  endtask

  initial begin
    int full_ticks, af_ticks, af_wr, ones, guard;

    @(negedge wr_clk);
    // Reset held with valid asserted: nothing accepted, nothing written.
    do_reset(10);
    $display("reset: s_ready=%0b wr_en=%0b word_cnt=%0d", o_ready, o_wr_en, o_word_cnt);
    step();
    step();
    check("ready_after_release", {31'd0, o_ready}, 32'd1);

    // Back-to-back stream of 20 words.
    do_reset(3);
    src_base = 0; src_n = 20;
    guard = 0;
    while (writes < 20 && guard < 200) begin step(); guard++; end
    analyze();
    check("t2_word_cnt", o_word_cnt, 32'd20);
    check("t2_latency", 32'(wr_first - hs_first), 32'd2);
    check("t2_nruns", 32'(runs.size()), 32'd3);
    check("t2_run0", 32'(qget(runs, 0)), 32'd8);
    check("t2_run1", 32'(qget(runs, 1)), 32'd8);
    check("t2_run2", 32'(qget(runs, 2)), 32'd4);
    check("t2_gap0", 32'(qget(gaps, 0)), 32'd1);
    check("t2_gap1", 32'(qget(gaps, 1)), 32'd1);
    $display("stream20: word_cnt=%0d runs=%p gaps=%p", o_word_cnt, runs, gaps);

    // Almost-full at start blocks bursts; two words buffer, then ready drops.
    do_reset(3);
    fifo_almost_full = 1'b1;
    src_base = 0; src_n = 3;
    repeat (6) step();
    ones = 0;
    foreach (wr_trace[i]) ones += int'(wr_trace[i]);
    check("t3_no_wr", 32'(ones), 32'd0);
    check("t3_ready", {31'd0, o_ready}, 32'd0);
    check("t3_buffered", 32'(src_idx), 32'd2);
    fifo_almost_full = 1'b0;
    guard = 0;
    while (writes < 3 && guard < 50) begin step(); guard++; end
    check("t3_word_cnt", o_word_cnt, 32'd3);
    $display("almost_full: word_cnt=%0d", o_word_cnt);

    // Full for 5 cycles after the 3rd write of a burst.
    do_reset(3);
    src_base = 16'h40; src_n = 8;
    full_ticks = 0; guard = 0;
    while (writes < 8 && guard < 200) begin
      fifo_full = (writes >= 3) && (full_ticks < 5);
      step();
      if (fifo_full) full_ticks++;
      guard++;
    end
    fifo_full = 1'b0;
    step();
    analyze();
    check("t4_stall_cnt", o_stall_cnt, 32'd5);
    check("t4_run0", 32'(qget(runs, 0)), 32'd3);
    check("t4_run1", 32'(qget(runs, 1)), 32'd5);
    check("t4_gap0", 32'(qget(gaps, 0)), 32'd6);
    $display("full_stall: stall_cnt=%0d runs=%p gaps=%p", o_stall_cnt, runs, gaps);

    // Asynchronous reset in the middle of a burst with two words buffered.
    do_reset(3);
    src_base = 16'h50; src_n = 3;
    fifo_almost_full = 1'b1;
    repeat (3) step();
    fifo_almost_full = 1'b0;
    step();
    step();
    fifo_full = 1'b1;
    step();
    fifo_full = 1'b0;
    step();
    #1;
    check("t5_wr_en_before", {31'd0, o_wr_en}, 32'd1);
    check("t5_stall_before", o_stall_cnt, 32'd1);
    check("t5_word_before", o_word_cnt, 32'd1);
    wr_rst_n = 1'b0;
    #1;
    check("t5_wr_en_async", {31'd0, o_wr_en}, 32'd0);
    check("t5_word_async", o_word_cnt, 32'd0);
    check("t5_stall_async", o_stall_cnt, 32'd0);
    check("t5_ready_async", {31'd0, o_ready}, 32'd0);
    check("t5_data_async", {16'd0, o_wr_data}, 32'd0);
    do_reset(3);
    src_base = 16'h100; src_n = 4;
    guard = 0;
    while (writes < 4 && guard < 100) begin step(); guard++; end
    check("t5_first_data", {16'd0, first_data}, 32'h100);
    check("t5_word_cnt", o_word_cnt, 32'd4);
    $display("mid_reset: first_data=0x%0h word_cnt=%0d", first_data, o_word_cnt);

    // Single-word bursts, with almost-full raised after the 2nd write.
    use_b = 1'b1;
    do_reset(3);
    src_base = 16'h200; src_n = 4;
    af_ticks = 0; af_wr = 0; guard = 0;
    while (writes < 4 && guard < 200) begin
      fifo_almost_full = (writes >= 2) && (af_ticks < 4);
      step();
      if (fifo_almost_full) begin
        af_ticks++;
        af_wr += int'(wr_trace[$]);
      end
      guard++;
    end
    fifo_almost_full = 1'b0;
    analyze();
    check("t6_writes_in_af", 32'(af_wr), 32'd0);
    check("t6_nruns", 32'(runs.size()), 32'd4);
    check("t6_run_max", 32'((qget(runs, 0) | qget(runs, 1) | qget(runs, 2) | qget(runs, 3))), 32'd1);
    check("t6_gap0", 32'(qget(gaps, 0)), 32'd1);
    check("t6_gap1", 32'(qget(gaps, 1)), 32'd5);
    check("t6_gap2", 32'(qget(gaps, 2)), 32'd1);
    $display("burst_len1: runs=%p gaps=%p", runs, gaps);

    // Random valid / full / almost-full traffic against the model.
    use_b = 1'b0;
    do_reset(3);
    src_base = int'($urandom_range(16'hffff)); src_n = 300; valid_pct = 70;
    guard = 0;
    while (writes < 300 && guard < 4000) begin
      fifo_full = ($urandom_range(99) < 20);
      fifo_almost_full = ($urandom_range(99) < 30);
      step();
      guard++;
    end
    fifo_full = 1'b0;
    fifo_almost_full = 1'b0;
    step();
    check("t7_accepted", 32'(src_idx), 32'd300);
    check("t7_word_cnt", o_word_cnt, 32'd300);
    $display("random: word_cnt=%0d stall_cnt=%0d", o_word_cnt, o_stall_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
